// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file write arbiter.
// Covers data/select widths, register count, and the requester identity
// that doubles as the arbiter's last-grant state.
package regfile_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 2;
    localparam int NREG   = 1 << ADDR_W;

    // Identifies a writeback source; the arbiter state stores the most
    // recent winner using the same encoding.
    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_MEM = 1'b1
    } req_id_t;

    // One-hot mask selecting register idx, used to build the scoreboard
    // set and clear vectors.
    function automatic logic [NREG-1:0] reg_onehot(input logic [ADDR_W-1:0] idx);
        logic [NREG-1:0] mask;
        mask      = '0;
        mask[idx] = 1'b1;
        return mask;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter between the ALU and load writeback sources.
// Grants are combinational from the requests; the registered state remembers
// which source won last so that a simultaneous request goes to the other one.
module rr_arb2
    import regfile_pkg::*;
(
    input  logic CLK,
    input  logic RST,
    input  logic alu_req_i,
    input  logic mem_req_i,
    output logic alu_gnt_o,
    output logic mem_gnt_o
);

    req_id_t state_q;
    req_id_t state_d;

    // Last-grant register; resets so that the ALU wins the first contention.
    always_ff @(posedge CLK or posedge RST) begin
        // NOTE: sequential state uses non-blocking assignment so every flop
        // samples pre-edge values regardless of block ordering.
        if (RST) begin
            state_q <= REQ_MEM;
        end else begin
            state_q <= state_d;
        end
    end

    // Grant selection and last-grant update.
    always_comb begin
        // NOTE: every output of this block is given a default first, so no
        // path through the case can leave a signal unassigned and infer a latch.
        alu_gnt_o = 1'b0;
        mem_gnt_o = 1'b0;
        state_d   = state_q;

        case ({alu_req_i, mem_req_i})
            2'b10: alu_gnt_o = 1'b1;
            2'b01: mem_gnt_o = 1'b1;
            2'b11: begin
                // Contention: the source that did not win last time goes now.
                if (state_q == REQ_MEM) begin
                    alu_gnt_o = 1'b1;
                end else begin
                    mem_gnt_o = 1'b1;
                end
            end
            default: ;
        endcase

        if (alu_gnt_o) begin
            state_d = REQ_ALU;
        end else if (mem_gnt_o) begin
            state_d = REQ_MEM;
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Write-port sequencer for the 4x8-bit register file.
// Arbitrates ALU and load writebacks onto one registered write port, keeps a
// per-register scoreboard of pending writes, stalls issue on RAW/WAW hazards
// and flags writes that land on a register nobody was waiting for.
// Optional macro REGFILE_ARB_BYPASS_EN adds two combinational read-bypass
// muxes that forward the in-flight write to the operand read ports.
module regfile_write_arbiter
    import regfile_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,

    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_dst,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_ready,

    input  logic              mem_valid,
    input  logic [ADDR_W-1:0] mem_dst,
    input  logic [DATA_W-1:0] mem_data,
    output logic              mem_ready,

    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_dst,
    input  logic [ADDR_W-1:0] issue_src_a,
    input  logic [ADDR_W-1:0] issue_src_b,
    output logic              issue_stall,

    output logic              rf_write_bit,
    output logic [ADDR_W-1:0] rf_selector_e,
    output logic [DATA_W-1:0] rf_data_in,

`ifdef REGFILE_ARB_BYPASS_EN
    input  logic [ADDR_W-1:0] byp_sel_a,
    input  logic [ADDR_W-1:0] byp_sel_b,
    input  logic [DATA_W-1:0] rd_data_a,
    input  logic [DATA_W-1:0] rd_data_b,
    output logic [DATA_W-1:0] byp_data_a,
    output logic [DATA_W-1:0] byp_data_b,
`endif

    output logic [NREG-1:0]   busy,
    output logic              err_unclaimed
);

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic              alu_gnt;
    logic              mem_gnt;
    logic              gnt_any;
    logic [ADDR_W-1:0] gnt_dst;
    logic [DATA_W-1:0] gnt_data;

    rr_arb2 u_arb (
        .CLK       (CLK),
        .RST       (RST),
        .alu_req_i (alu_valid),
        .mem_req_i (mem_valid),
        .alu_gnt_o (alu_gnt),
        .mem_gnt_o (mem_gnt)
    );

    assign alu_ready = alu_gnt;
    assign mem_ready = mem_gnt;

    // Steer the winning source's destination and data toward the write stage.
    always_comb begin
        gnt_any  = alu_gnt | mem_gnt;
        gnt_dst  = mem_dst;
        gnt_data = mem_data;
        if (alu_gnt) begin
            gnt_dst  = alu_dst;
            gnt_data = alu_data;
        end
    end

    // ------------------------------------------------------------------
    // Registered write stage
    // ------------------------------------------------------------------
    logic              wr_en_q,   wr_en_d;
    logic [ADDR_W-1:0] wr_sel_q,  wr_sel_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;

    // Load the granted write; without a grant only the enable drops and the
    // select/data keep their last value.
    always_comb begin
        wr_en_d   = gnt_any;
        wr_sel_d  = wr_sel_q;
        wr_data_d = wr_data_q;
        if (gnt_any) begin
            wr_sel_d  = gnt_dst;
            wr_data_d = gnt_data;
        end
    end

    // Write-stage register; reset discards any write sitting in it.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_en_q   <= 1'b0;
            wr_sel_q  <= '0;
            wr_data_q <= '0;
        end else begin
            wr_en_q   <= wr_en_d;
            wr_sel_q  <= wr_sel_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign rf_write_bit  = wr_en_q;
    assign rf_selector_e = wr_sel_q;
    assign rf_data_in    = wr_data_q;

    // ------------------------------------------------------------------
    // Scoreboard and hazard detection
    // ------------------------------------------------------------------
    logic [NREG-1:0] busy_q, busy_d;
    logic [NREG-1:0] set_mask;
    logic [NREG-1:0] clr_mask;
    logic            issue_fire;

    // An instruction stalls if either source is awaiting a write (RAW) or its
    // destination already has a write outstanding (WAW).
    always_comb begin
        issue_stall = issue_valid &
                      (busy_q[issue_src_a] | busy_q[issue_src_b] | busy_q[issue_dst]);
        issue_fire  = issue_valid & ~issue_stall;
    end

    // A committing write frees its register; an issuing instruction claims
    // its destination. Applying the set after the clear lets a same-edge
    // claim survive the commit of an older write to that register.
    always_comb begin
        set_mask = issue_fire ? reg_onehot(issue_dst) : '0;
        clr_mask = wr_en_q    ? reg_onehot(wr_sel_q)  : '0;
        busy_d   = (busy_q & ~clr_mask) | set_mask;
    end

    // Scoreboard register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;

    // ------------------------------------------------------------------
    // Unclaimed-write error
    // ------------------------------------------------------------------
    logic err_q, err_d;

    // Sticky flag: a granted writeback whose destination has no pending claim
    // means the pipeline wrote a register no instruction was waiting on.
    always_comb begin
        err_d = err_q | (gnt_any & ~busy_q[gnt_dst]);
    end

    // Error flag register; only reset clears it.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_unclaimed = err_q;

`ifdef REGFILE_ARB_BYPASS_EN
    // ------------------------------------------------------------------
    // Read bypass
    // ------------------------------------------------------------------
    // Forward the write currently presented to the register file, since the
    // file itself will only return it after it commits on the next edge.
    always_comb begin
        byp_data_a = rd_data_a;
        byp_data_b = rd_data_b;
        if (wr_en_q && (wr_sel_q == byp_sel_a)) begin
            byp_data_a = wr_data_q;
        end
        if (wr_en_q && (wr_sel_q == byp_sel_b)) begin
            byp_data_b = wr_data_q;
        end
    end
`endif

endmodule
